// File: rtl/seg_scan_decoder.sv
// Recovers hex digits from a multiplexed, active-low 7-segment scan and publishes whole frames.
// Latency: a frame appears one edge after its last digit is captured; no backpressure, valid is a single pulse.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  SEG,
  input  logic [7:0]  AN,
  output logic [31:0] value,
  output logic [7:0]  dp,
  output logic        valid,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 2);

  logic [7:0]  prev_seg;
  logic [7:0]  prev_an;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic [31:0] shadow;
  logic [7:0]  shadow_dp;
  logic [7:0]  mask;
  logic [7:0]  mask_nxt;
  logic        err;
  logic        err_nxt;
  logic [7:0]  an_sel;
  logic        an_ok;
  logic        same;
  logic        capture;
  logic        publish;
  logic [2:0]  digit;
  logic [3:0]  glyph_nib;
  logic        glyph_ok;

  assign an_sel  = ~AN;
  assign an_ok   = (an_sel != 8'd0) && ((an_sel & (an_sel - 8'd1)) == 8'd0);
  assign same    = ({AN, SEG} == {prev_an, prev_seg});
  assign capture = an_ok && same && (cnt == CNT_CAP);
  assign publish = (mask == 8'hFF);

  always_comb begin
    digit = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (an_sel[i]) digit = 3'(i);
    end
  end

  always_comb begin
    glyph_ok  = 1'b1;
    glyph_nib = 4'h0;
    case (SEG[6:0])
      7'h40: glyph_nib = 4'h0;
      7'h79: glyph_nib = 4'h1;
      7'h24: glyph_nib = 4'h2;
      7'h30: glyph_nib = 4'h3;
      7'h19: glyph_nib = 4'h4;
      7'h12: glyph_nib = 4'h5;
      7'h02: glyph_nib = 4'h6;
      7'h78: glyph_nib = 4'h7;
      7'h00: glyph_nib = 4'h8;
      7'h10: glyph_nib = 4'h9;
      7'h08: glyph_nib = 4'hA;
      7'h03: glyph_nib = 4'hB;
      7'h46: glyph_nib = 4'hC;
      7'h21: glyph_nib = 4'hD;
      7'h06: glyph_nib = 4'hE;
      7'h0E: glyph_nib = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  always_comb begin
    cnt_nxt = 8'd0;
    if (an_ok && same) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 8'd1;
  end

  // Publishing clears the frame first so a same-edge capture lands in the new frame.
  always_comb begin
    mask_nxt = publish ? 8'd0 : mask;
    err_nxt  = publish ? 1'b0 : err;
    if (capture) begin
      mask_nxt = mask_nxt | (8'd1 << digit);
      err_nxt  = err_nxt | ~glyph_ok;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_seg  <= 8'hFF;
      prev_an   <= 8'hFF;
      cnt       <= 8'd0;
      shadow    <= 32'd0;
      shadow_dp <= 8'd0;
      mask      <= 8'd0;
      err       <= 1'b0;
      value     <= 32'd0;
      dp        <= 8'd0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      prev_seg <= SEG;
      prev_an  <= AN;
      cnt      <= cnt_nxt;
      mask     <= mask_nxt;
      err      <= err_nxt;
      valid    <= publish;
      if (publish) begin
        value     <= shadow;
        dp        <= shadow_dp;
        frame_err <= err;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (capture) begin
        shadow[{digit, 2'b00} +: 4] <= glyph_ok ? glyph_nib : 4'h0;
        shadow_dp[digit]            <= ~SEG[7];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized and directed scan stimulus checked cycle by cycle against a run-length frame model.
module tb_seg_scan_decoder;

  localparam int S = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  SEG;
  logic [7:0]  AN;
  logic [31:0] value;
  logic [7:0]  dp;
  logic        valid;
  logic        frame_err;
  logic [15:0] frame_cnt;

  seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .SEG(SEG), .AN(AN),
    .value(value), .dp(dp), .valid(valid), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [6:0] glyph_tab [16];

  // Model: a pair is captured once it has been sampled on S consecutive edges.
  int          run;
  logic [15:0] last_pair;
  logic [3:0]  m_nib [8];
  logic [7:0]  m_dp;
  logic [7:0]  m_have;
  logic        m_err;
  logic        m_pend;
  logic [31:0] exp_value;
  logic [7:0]  exp_dp;
  logic        exp_err;
  logic [15:0] exp_cnt;
  logic        exp_valid;

  function automatic int decode(input logic [6:0] s);
    for (int k = 0; k < 16; k++) if (glyph_tab[k] == s) return k;
    return -1;
  endfunction

  function automatic logic [7:0] an_of(input int i);
    logic [7:0] one;
    one = 8'h01 << i;
    return ~one;
  endfunction

  function automatic logic [7:0] seg_of(input int d, input logic lit);
    return {~lit, glyph_tab[d]};
  endfunction

  task automatic model_reset();
    run = 0; last_pair = 16'hFFFF;
    for (int k = 0; k < 8; k++) m_nib[k] = 4'h0;
    m_dp = 0; m_have = 0; m_err = 0; m_pend = 0;
    exp_value = 0; exp_dp = 0; exp_err = 0; exp_cnt = 0; exp_valid = 0;
  endtask

  task automatic model_edge();
    int idx;
    int d;
    logic ok;
    exp_valid = 1'b0;
    if (m_pend) begin
      for (int k = 0; k < 8; k++) exp_value[4*k +: 4] = m_nib[k];
      exp_dp = m_dp; exp_err = m_err; exp_cnt = exp_cnt + 16'd1; exp_valid = 1'b1;
      m_have = 0; m_err = 0; m_pend = 0;
    end
    ok = ($countones(~AN) == 1);
    if (!ok) run = 0;
    else if ({AN, SEG} == last_pair) run = run + 1;
    else run = 1;
    last_pair = {AN, SEG};
    if (ok && run == S) begin
      idx = 0;
      for (int k = 0; k < 8; k++) if (!AN[k]) idx = k;
      d = decode(SEG[6:0]);
      m_nib[idx] = (d < 0) ? 4'h0 : 4'(d);
      if (d < 0) m_err = 1'b1;
      m_dp[idx] = ~SEG[7];
      m_have[idx] = 1'b1;
      if (m_have == 8'hFF) m_pend = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("valid", valid, exp_valid);
    check_eq("value", value, exp_value);
    check_eq("dp", dp, exp_dp);
    check_eq("frame_err", frame_err, exp_err);
    check_eq("frame_cnt", frame_cnt, exp_cnt);
  endtask

  task automatic hold(input logic [7:0] an, input logic [7:0] seg, input int n);
    AN = an; SEG = seg;
    repeat (n) cycle();
  endtask

  task automatic reset_pulse();
    #2 rst = 1'b0;
    #1 model_reset();
    check_eq("rst_value", value, 32'd0);
    check_eq("rst_dp", dp, 8'd0);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_err", frame_err, 1'b0);
    check_eq("rst_cnt", frame_cnt, 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord [8];
    int j;
    int t;
    int d;
    logic [7:0] sg;
    glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    AN = 8'hFF; SEG = 8'hFF; rst = 1'b1;
    #3 reset_pulse();

    // Ordered frame 1..8 on digits 0..7.
    for (int i = 0; i < 8; i++) hold(an_of(i), seg_of(i + 1, 1'b0), 20);
    hold(8'hFF, 8'hFF, 3);
    check_eq("frame1_value", value, 32'h87654321);
    check_eq("frame1_cnt", frame_cnt, 16'd1);

    // One cycle short of stable: digit 0 must not count towards the next frame.
    hold(8'hFE, 8'h40, 15);
    hold(8'hFF, 8'hFF, 5);
    for (int i = 1; i < 8; i++) hold(an_of(i), seg_of(0, 1'b0), 20);
    hold(8'hFF, 8'hFF, 5);
    check_eq("short_hold_cnt", frame_cnt, 16'd1);
    hold(an_of(0), seg_of(0, 1'b0), 20);
    hold(8'hFF, 8'hFF, 3);
    check_eq("short_hold_done", frame_cnt, 16'd2);

    // Blank glyph on digit 3, lit point on digit 0.
    for (int i = 7; i >= 0; i--)
      hold(an_of(i), (i == 3) ? 8'h7F : (i == 0) ? 8'h79 : seg_of(i, 1'b0), 20);
    hold(8'hFF, 8'hFF, 3);
    check_eq("blank_nib3", value[15:12], 4'h0);
    check_eq("blank_nib0", value[3:0], 4'h1);
    check_eq("blank_dp0", dp[0], 1'b1);
    check_eq("blank_err", frame_err, 1'b1);
    for (int i = 0; i < 8; i++) hold(an_of(i), seg_of(9, 1'b0), 18);
    hold(8'hFF, 8'hFF, 3);
    check_eq("clean_err", frame_err, 1'b0);

    // Two enables at once, then a glitching enable.
    hold(8'hFC, 8'hC0, 40);
    for (int k = 0; k < 10; k++) hold((k % 2) ? 8'hFE : 8'hFD, 8'hC0, 3);
    hold(8'hFF, 8'hFF, 5);
    check_eq("bad_an_cnt", frame_cnt, 16'd4);

    // Random order, holds around the threshold, stray glyphs and enable noise.
    repeat (14) begin
      for (int k = 0; k < 8; k++) ord[k] = k;
      for (int k = 7; k > 0; k--) begin
        j = $urandom_range(k, 0); t = ord[k]; ord[k] = ord[j]; ord[j] = t;
      end
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(5, 0) == 0) begin
          case ($urandom_range(2, 0))
            0: hold(8'hFF, SEG, $urandom_range(4, 1));
            1: hold(8'h00, SEG, $urandom_range(4, 1));
            default: hold(8'hF0, SEG, $urandom_range(4, 1));
          endcase
        end
        d = $urandom_range(15, 0);
        sg = seg_of(d, 1'($urandom_range(1, 0)));
        if ($urandom_range(7, 0) == 0) sg = 8'($urandom_range(255, 0));
        hold(an_of(ord[k]), sg, $urandom_range(S + 6, S - 3));
      end
    end
    hold(8'hFF, 8'hFF, 3);

    // Reset mid-frame, then an all-F frame.
    for (int i = 0; i < 5; i++) hold(an_of(i), seg_of(i, 1'b0), 20);
    reset_pulse();
    for (int i = 0; i < 8; i++) hold(an_of(i), 8'h8E, 20);
    hold(8'hFF, 8'hFF, 3);
    check_eq("post_rst_value", value, 32'hFFFFFFFF);
    check_eq("post_rst_cnt", frame_cnt, 16'd1);

    // Counter wrap from a preloaded 16'hFFFF.
    force dut.frame_cnt = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    cycle();
    release dut.frame_cnt;
    hold(8'hFF, 8'hFF, 2);
    for (int i = 0; i < 8; i++) hold(an_of(i), seg_of(7 - i, 1'b1), 20);
    hold(8'hFF, 8'hFF, 3);
    check_eq("wrap_cnt", frame_cnt, 16'd0);
    check_eq("wrap_dp", dp, 8'hFF);
    check_eq("wrap_value", value, 32'h01234567);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 16, number of consecutive clk cycles an AN/SEG pair SHALL hold unchanged before it is captured (legal range 2..255).
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 SHALL reset all state immediately, independent of clk.
REQ-004 SEG  input  8  active-low segment bus from the display driver; SEG[0..6]=a..g, SEG[7]=dp.
REQ-005 AN  input  8  active-low digit enables; AN[i]=0 selects digit i.
REQ-006 value  output  32  last complete decoded frame; digit i in value[4i+3:4i].
REQ-007 dp  output  8  last complete frame decimal points, dp[i]=1 when digit i's point is lit.
REQ-008 valid  output  1  one-cycle pulse when value/dp/frame_err update.
REQ-009 frame_err  output  1  set when the published frame contained any non-hex glyph.
REQ-010 frame_cnt  output  16  count of published frames.

Function
REQ-011 The block SHALL register SEG and AN each cycle (prev_seg, prev_an) and keep an 8-bit stable counter cnt.
REQ-012 AN SHALL be valid only when exactly one bit is 0; when invalid, cnt SHALL be 0 and no capture SHALL occur.
REQ-013 When AN is valid and {AN,SEG} equals {prev_an,prev_seg}, cnt SHALL increment, saturating at STABLE_CYCLES; otherwise cnt SHALL load 0.
REQ-014 A capture SHALL occur on the edge where cnt goes from STABLE_CYCLES-2 to STABLE_CYCLES-1, exactly once per stable interval; input held constant from edge t captures at edge t+STABLE_CYCLES-1.
REQ-015 Decode of SEG[6:0] (bit order g..a, hex, active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-016 On capture of digit i, the shadow nibble i SHALL be written with the decoded value, shadow dp[i] with ~SEG[7], and mask[i] set to 1.
REQ-017 A pattern absent from REQ-015 SHALL write nibble 0 and set the sticky shadow error flag.
REQ-018 Recapturing a digit already in mask SHALL overwrite its nibble/dp without error.
REQ-019 On the edge after mask becomes 8'hFF, the block SHALL copy shadow to value/dp, copy the error flag to frame_err, assert valid for exactly one cycle, increment frame_cnt (wrapping 16'hFFFF->0), and clear mask and error flag.
REQ-020 A capture coinciding with the publish edge SHALL be applied to the new (cleared) frame: its mask bit and error SHALL survive the clear.
REQ-021 Digits SHALL be accepted in any order; scan direction is not assumed.
REQ-022 value, dp, frame_err SHALL hold between publishes; partial frames SHALL never be visible.

Reset
REQ-023 On rst=0: value=0, dp=0, valid=0, frame_err=0, frame_cnt=0, cnt=0, mask=0, shadow=0, error flag=0, prev_an=8'hFF, prev_seg=8'hFF.
REQ-024 Reset mid-frame SHALL discard the partial frame; after release, capture restarts with an empty mask.

Verification
REQ-025 Scan digits 0..7 with glyphs for 1,2,3,4,5,6,7,8, each held 20 cycles, STABLE_CYCLES=16 -> one valid pulse, value=32'h87654321, dp=0, frame_err=0, frame_cnt=1.
REQ-026 Hold AN=8'hFE, SEG=8'h40 exactly 15 cycles, then AN=8'hFF -> no capture, mask stays 0, valid never asserts.
REQ-027 Frame with digit 3 SEG=8'h7F (blank) and digit 0 SEG=8'h79 with dp lit (SEG[7]=0) -> value[15:12]=0, value[3:0]=1, dp[0]=1, frame_err=1; next clean frame -> frame_err=0.
REQ-028 AN=8'hFC (two digits) held 40 cycles -> no capture; AN glitching every 3 cycles -> no capture.
REQ-029 Assert rst=0 after 5 digits captured, release, scan full frame 8'h..=all 'F' -> value=32'hFFFFFFFF, frame_cnt=1, no stale digits.
REQ-030 Preload 65535 frames -> next publish gives frame_cnt=0 with valid=1.
